// File: rtl/pwm_timebase.sv
// pwm_timebase: PWM time-base counter with prescaler, up/down/up-down modes, one-shot and registered wrap pulses; PWM_TIMEBASE_SHADOW_EN shadows period/prescale
module pwm_timebase #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             count_reset,
  input  logic [1:0]       mode,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] period,
  input  logic [PSC_W-1:0] prescale,
  output logic [WIDTH-1:0] count_val,
  output logic             dir,
  output logic             ovf,
  output logic             unf,
  output logic             running
);
  logic [PSC_W-1:0] psc_cnt;
  logic [WIDTH-1:0] period_eff;
  logic [PSC_W-1:0] prescale_eff;
  logic [WIDTH-1:0] nxt_cnt;
  logic is_dn, is_ud, tick, step, top, bot, ev_ovf, ev_unf, eoc, nxt_dir;
  always_comb begin
    is_dn = mode == 2'b01;
    is_ud = mode == 2'b10;
    tick = psc_cnt >= prescale_eff;
    step = en && running && tick;
    top = count_val >= period_eff;
    bot = count_val == '0;
    ev_ovf = is_dn ? 1'b0 : is_ud ? (dir && top) : top;
    ev_unf = is_dn ? bot : is_ud ? (!dir && bot) : 1'b0;
    eoc = (is_dn || is_ud) ? ev_unf : ev_ovf;
    nxt_cnt = is_dn ? (bot ? period_eff : count_val - WIDTH'(1))
            : is_ud ? (ev_ovf ? ((period_eff == '0) ? '0 : period_eff - WIDTH'(1))
                     : ev_unf ? WIDTH'(1)
                     : dir ? count_val + WIDTH'(1) : count_val - WIDTH'(1))
            : (top ? '0 : count_val + WIDTH'(1));
    nxt_dir = is_dn ? 1'b0 : is_ud ? (ev_ovf ? (period_eff == '0) : ev_unf ? 1'b1 : dir) : 1'b1;
  end
`ifdef PWM_TIMEBASE_SHADOW_EN
  logic [WIDTH-1:0] period_sh;
  logic [PSC_W-1:0] prescale_sh;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_sh <= '0;
      prescale_sh <= '0;
    end else if (count_reset || (step && eoc)) begin
      period_sh <= period;
      prescale_sh <= prescale;
    end
  end
  assign period_eff = period_sh;
  assign prescale_eff = prescale_sh;
`else
  assign period_eff = period;
  assign prescale_eff = prescale;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt <= '0;
      count_val <= '0;
      dir <= 1'b1;
      ovf <= 1'b0;
      unf <= 1'b0;
      running <= 1'b1;
    end else if (count_reset) begin
      psc_cnt <= '0;
      count_val <= is_dn ? period : '0;
      dir <= !is_dn;
      ovf <= 1'b0;
      unf <= 1'b0;
      running <= 1'b1;
    end else begin
      ovf <= step && ev_ovf;
      unf <= step && ev_unf;
      if (en && running) psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
      if (step) begin
        count_val <= nxt_cnt;
        dir <= nxt_dir;
        if (one_shot && eoc) running <= 1'b0;
      end
    end
  end
endmodule
